mant_scheduler: RTL and testbench

Maintenance scheduler sharing one maintenance crew between `N_MACH` machines. Each machine has its own saturating cycle counter. A machine raises a pending request when its count reaches `THRESH` or when it receives a manual request. A round-robin arbiter grants the crew to one pending machine at a time, holds it for `MANT_LEN` cycles, then clears that machine's cycle count and bumps a global maintenance tally. The block sits above the per-machine cycle/maintenance counters and drives the status message bus.

---
 rtl/mant_scheduler.sv | 129 ++++++++++++
 tb/tb_mant_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mant_scheduler.sv
// Maintenance scheduler: per-machine saturating cycle counters feeding a
// round-robin arbiter that assigns a single crew for MANT_LEN cycles at a time.
module mant_lane #(
  parameter int THRESH = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       m_req,
  input  logic       hold,
  input  logic       clr,
  output logic [7:0] cnt,
  output logic       pend
);
  localparam logic [7:0] TH = 8'(THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else if (!hold) begin
      if (run && cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (cnt >= TH || m_req) pend <= 1'b1;
    end
  end
endmodule

module mant_scheduler #(
  parameter int N_MACH   = 4,
  parameter int THRESH   = 200,
  parameter int MANT_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MACH-1:0]         run,
  input  logic [N_MACH-1:0]         m_req,
  output logic [8*N_MACH-1:0]       cyc_cnt,
  output logic [N_MACH-1:0]         pending,
  output logic                      busy,
  output logic [$clog2(N_MACH)-1:0] grant_id,
  output logic                      done,
  output logic [7:0]                total_mant,
  output logic [7:0]                msg
);
  localparam int IW = $clog2(N_MACH);

  typedef enum logic [1:0] {IDLE, GRANT, SERVICE, DONE} state_t;

  state_t        state;
  logic [7:0]    svc_cnt;
  logic [IW-1:0] last_id;
  logic [IW-1:0] next_id;
  logic          found;
  logic [7:0]    total_inc;

  for (genvar i = 0; i < N_MACH; i++) begin : g_lane
    mant_lane #(.THRESH(THRESH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .run   (run[i]),
      .m_req (m_req[i]),
      .hold  (busy && grant_id == IW'(i)),
      .clr   (state == DONE && grant_id == IW'(i)),
      .cnt   (cyc_cnt[8*i +: 8]),
      .pend  (pending[i])
    );
  end

  // Search starts one past the last serviced machine so every machine gets a turn.
  always_comb begin
    next_id = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_MACH; k++) begin
      if (!found && pending[(int'(last_id) + k) % N_MACH]) begin
        next_id = IW'((int'(last_id) + k) % N_MACH);
        found   = 1'b1;
      end
    end
  end

  assign total_inc = (total_mant == 8'hFF) ? 8'hFF : total_mant + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      svc_cnt    <= '0;
      last_id    <= IW'(N_MACH - 1);
      grant_id   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      total_mant <= '0;
      msg        <= '0;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          state    <= GRANT;
          grant_id <= next_id;
          busy     <= 1'b1;
        end
        GRANT: begin
          svc_cnt <= 8'(MANT_LEN - 1);
          state   <= SERVICE;
          msg     <= 8'hFF;
        end
        SERVICE: begin
          if (svc_cnt == 8'd0) begin
            state <= DONE;
            done  <= 1'b1;
            msg   <= total_mant;
          end else begin
            svc_cnt <= svc_cnt - 8'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          total_mant <= total_inc;
          msg        <= total_inc;
          last_id    <= grant_id;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mant_scheduler.sv
// Bench for mant_scheduler: directed scenarios plus random traffic, all checked
// against a phase-timeline model of the scheduling rules.
module tb_mant_scheduler;
  localparam int N = 4, TH = 200, L = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     run = '0;
  logic [N-1:0]     m_req = '0;
  logic [8*N-1:0]   cyc_cnt;
  logic [N-1:0]     pending;
  logic             busy;
  logic [1:0]       grant_id;
  logic             done;
  logic [7:0]       total_mant;
  logic [7:0]       msg;

  mant_scheduler #(.N_MACH(N), .THRESH(TH), .MANT_LEN(L)) dut (
    .clk(clk), .rst(rst), .run(run), .m_req(m_req), .cyc_cnt(cyc_cnt),
    .pending(pending), .busy(busy), .grant_id(grant_id), .done(done),
    .total_mant(total_mant), .msg(msg)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_done = 0;
  int gq[$];

  // Model: m_t is time since grant: -1 idle, 0 grant, 1..L service, L+1 done.
  int m_cnt[N];
  bit m_pend[N];
  int m_t, m_g, m_last, m_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_pend[i] = 0; end
    m_t = -1; m_g = 0; m_last = N - 1; m_total = 0;
  endtask

  task automatic model_step();
    int nc[N];
    bit np[N];
    bit any;
    bit in_svc;
    bit in_done;
    in_svc  = (m_t >= 0);
    in_done = (m_t == L + 1);
    any = 0;
    for (int i = 0; i < N; i++) begin
      any = any | m_pend[i];
      nc[i] = m_cnt[i];
      np[i] = m_pend[i];
      if (in_done && i == m_g) begin
        nc[i] = 0; np[i] = 0;
      end else if (!(in_svc && i == m_g)) begin
        if (run[i]) nc[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
        if (m_cnt[i] >= TH || m_req[i]) np[i] = 1;
      end
    end
    if (m_t < 0) begin
      if (any) begin
        for (int k = N; k >= 1; k--)
          if (m_pend[(m_last + k) % N]) m_g = (m_last + k) % N;
        m_t = 0;
      end
    end else if (in_done) begin
      m_total = (m_total >= 255) ? 255 : m_total + 1;
      m_last = m_g;
      m_t = -1;
    end else begin
      m_t++;
    end
    for (int i = 0; i < N; i++) begin m_cnt[i] = nc[i]; m_pend[i] = np[i]; end
  endtask

  task automatic compare_all();
    logic [N-1:0] mp;
    for (int i = 0; i < N; i++) begin
      mp[i] = m_pend[i];
      chk($sformatf("cnt%0d", i), 32'(cyc_cnt[8*i +: 8]), m_cnt[i]);
    end
    chk("pend", 32'(pending), 32'(mp));
    chk("busy", 32'(busy), 32'(m_t >= 0));
    chk("done", 32'(done), 32'(m_t == L + 1));
    chk("total", 32'(total_mant), m_total);
    chk("msg", 32'(msg), (m_t >= 1 && m_t <= L) ? 255 : m_total);
    if (m_t >= 0) chk("gid", 32'(grant_id), m_g);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (done) begin n_done++; gq.push_back(int'(grant_id)); end
  endtask

  task automatic wait_t(input int target, input string tag);
    int k = 0;
    while (m_t != target && k < 200) begin step(); k++; end
    if (k >= 200) chk({tag, "_tmo"}, m_t, target);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    run = N'($urandom); m_req = N'($urandom);
    #1;
    model_reset();
    compare_all();
    chk("rst_done", 32'(done), 0);
    run = '0; m_req = '0;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    run = N'($urandom); m_req = N'($urandom);
    #3;
    compare_all();
    chk("rst_msg", 32'(msg), 0);
    @(posedge clk); #1;
    compare_all();
    run = '0; m_req = '0;
    rst = 1'b0;

    // Threshold path on machine 0
    n_done = 0;
    run = 4'b0001;
    repeat (200) step();
    chk("thr_cnt", 32'(cyc_cnt[7:0]), 200);
    run = '0;
    step();
    chk("thr_pend", 32'(pending[0]), 1);
    repeat (14) step();
    chk("thr_ndone", n_done, 1);
    chk("thr_total", 32'(total_mant), 1);
    chk("thr_msg", 32'(msg), 1);
    chk("thr_cnt0", 32'(cyc_cnt[7:0]), 0);

    // Round-robin from a fresh pointer
    do_reset();
    gq.delete();
    m_req = 4'b1111; step(); m_req = '0;
    repeat (4 * (L + 4) + 4) step();
    chk("rr_n", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk($sformatf("rr_ord%0d", i), gq[i], i);
    chk("rr_total", 32'(total_mant), 4);
    chk("rr_pend", 32'(pending), 0);

    // Fairness: 3 follows 2 before wrapping to 0
    do_reset();
    gq.delete();
    m_req = 4'b0100; step(); m_req = '0;
    wait_t(3, "fair");
    m_req = 4'b1001; step(); m_req = '0;
    repeat (3 * (L + 4) + 4) step();
    chk("fair_n", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("fair0", gq[0], 2); chk("fair1", gq[1], 3); chk("fair2", gq[2], 0);
    end

    // Freeze: machine 1 inputs ignored during its own service
    do_reset();
    m_req = 4'b0010; step(); m_req = '0;
    wait_t(1, "frz");
    while (m_t >= 1 && m_t <= L) begin run = 4'b0010; m_req = 4'b0010; step(); end
    run = '0; m_req = '0;
    step();
    chk("frz_cnt", 32'(cyc_cnt[15:8]), 0);
    chk("frz_pend", 32'(pending[1]), 0);
    m_req = 4'b0010; step(); m_req = '0;
    chk("frz_rearm", 32'(pending[1]), 1);
    repeat (L + 6) step();

    // Async reset on the 4th service cycle
    do_reset();
    n_done = 0;
    m_req = 4'b0100; step(); m_req = '0;
    wait_t(4, "ar");
    do_reset();
    chk("ar_total", 32'(total_mant), 0);
    chk("ar_ndone", n_done, 0);
    m_req = 4'b1101; step(); m_req = '0;
    wait_t(0, "ar_g");
    chk("ar_grant", 32'(grant_id), 0);
    repeat (3 * (L + 4)) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      run = N'($urandom);
      for (int i = 0; i < N; i++) m_req[i] = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
